rxfifo: RTL
===========

Name: rxfifo

Overview:
- Receive buffer directly downstream of the rxuart receiver.
- Drains each completed byte from the receiver's valid/rd handshake the cycle it appears, so the receiver is idle again for the next start bit.
- Queues bytes in a small synchronous FIFO and presents them to the CPU I/O port with a show-ahead valid/data/rd interface.
- Also provides an occupancy count, an almost-full flag for flow control, and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).
- AFULL, 12, almost_full asserts when count >= AFULL; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetq  input  1  asynchronous active-low reset.
- rx_valid  input  1  receiver has a completed byte (rxuart valid).
- rx_data  input  8  receiver byte (rxuart data).
- rx_rd  output  1  read strobe to receiver (rxuart rd); combinational.
- rd  input  1  CPU pop strobe; one byte per cycle asserted.
- valid  output  1  FIFO non-empty; data is meaningful.
- data  output  8  head-of-FIFO byte (show-ahead).
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL.
- overflow  output  1  sticky: a received byte was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset resetq is asynchronous, active-low. While resetq is low, all registers clear immediately:
  - wptr = 0, rptr = 0, count = 0, overflow = 0.
  - Storage array is not reset.
- Reset values of outputs: valid = 0, data = 8'h00, count = 0, almost_full = 0, overflow = 0, rx_rd = 0. rx_rd is gated to 0 while resetq is low.
- Receiver side:
  - rx_rd = rx_valid (after reset gating); every presented byte is consumed in the same cycle.
  - pop = rd & valid.
  - push = rx_valid & (count != DEPTH | pop).
  - On push: mem[wptr] <= rx_data; wptr <= wptr+1, wrapping modulo DEPTH.
  - Drop case: rx_valid & count == DEPTH & !pop. rx_rd is still asserted; the byte is discarded, FIFO contents and pointers are unchanged, overflow <= 1.
  - The newest byte is the one dropped; stored data is never overwritten.
- CPU side:
  - valid = (count != 0).
  - data = mem[rptr] when valid, else 8'h00.
  - Show-ahead: the byte pushed at edge N is visible on data after edge N, so data is valid in cycle N+1.
  - On pop: rptr <= rptr+1, wrapping modulo DEPTH.
  - rd while empty is ignored: no pointer change, no error flag.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - Both, or neither: unchanged.
  - Push and pop on the same cycle when empty cannot occur, because pop requires valid.
- Full with simultaneous pop: the push is accepted, count stays DEPTH, and no overflow is flagged.
- almost_full: registered-equivalent, derived from the current count only; no hysteresis.
- overflow:
  - Set by any drop.
  - Cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins (overflow = 1).
- Latency: receiver byte to CPU-visible is 1 cycle. The receiver is re-armed on the edge after rx_valid.
- Pointers are DEPTH_LOG2 bits wide. count is tracked explicitly, so full and empty are unambiguous when wptr == rptr.

Test Plan:
- Reset, then single byte: pulse rx_valid with rx_data = 8'hA5.
  - rx_rd = 1 the same cycle.
  - Next cycle: valid = 1, data = 8'hA5, count = 1.
  - rd for one cycle: then valid = 0, data = 8'h00, count = 0.
- Fill: push 16 bytes 8'h00..8'h0F with no rd.
  - almost_full rises at count = 12; count = 16.
  - 17th byte 8'hFF: rx_rd = 1, overflow = 1, count stays 16.
  - Draining returns exactly 8'h00..8'h0F in order.
- Full with simultaneous events: at count = 16, assert rd and rx_valid (8'h77) together.
  - count stays 16, overflow stays 0.
  - 8'h77 emerges last after draining.
- Wrap-around: run 40 push/pop pairs with interleaved rd, keeping occupancy at 1..3.
  - Output sequence matches input sequence across pointer wrap.
  - count never exceeds 3.
- Flags and reset:
  - rd while empty: no change, valid stays 0.
  - Drop and clr_ovf in the same cycle: overflow = 1.
  - clr_ovf alone: overflow = 0.
  - Assert resetq low mid-stream with count = 5: valid, count, overflow and almost_full go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/rxfifo.sv
// rxfifo: byte queue between the rxuart receiver and the CPU port, with occupancy, almost-full and sticky overflow.
// Latency: a byte taken from the receiver at edge N is presented show-ahead on data during cycle N+1.
// Backpressure: none toward the receiver (rx_rd follows rx_valid); a byte arriving full with no pop is dropped and sets overflow.
module rxfifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL      = 12
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_rd,
    input  logic                  rd,
    output logic                  valid,
    output logic [7:0]            data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] AFULL_CNT = AFULL[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Handshake decode: the receiver is always drained; full-without-pop turns the take into a drop.
    always_comb begin
        rx_rd = rx_valid & resetq;
        valid = (count != '0);
        full  = (count == FULL_CNT);
        pop   = rd & valid;
        push  = rx_rd & (~full | pop);
        drop  = rx_rd & full & ~pop;
    end

    // Show-ahead head byte, forced to zero when empty so stale storage never leaks out.
    always_comb begin
        data        = valid ? mem[rptr] : 8'h00;
        almost_full = (count >= AFULL_CNT);
    end

    // Storage is not reset; only entries behind wptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= rx_data;
        end
    end

    // Pointers and explicit occupancy; count disambiguates full from empty when wptr == rptr.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as clr_ovf wins.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
